tgate_switch_seq: RTL
=====================

Name: tgate_switch_seq

Overview:
Sequencer that drives an array of N transmission-gate switches feeding one shared output node, then reads back that node. It accepts channel-select requests over a valid/ready handshake. Each switch gets a complementary enable pair (ne/pe) with break-before-make sequencing. It waits a settle time, then samples the shared node and returns the bit with a one-cycle valid pulse. It is the controlling and reading end for the tran_gate cell array.

Parameters:
N, 4, number of tgate channels (N >= 2)
DEAD, 2, all-off break cycles before a new channel closes (>= 1)
SETTLE, 3, cycles a channel is closed before the shared node is sampled (>= 1)
CW, $clog2(N), select width (derived, localparam)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_sel  input  CW  requested channel index
ne  output  N  n-side enables, at most one bit high
pe  output  N  p-side enables, always bitwise ~ne
y_in  input  1  shared tgate output node
rd_valid  output  1  one-cycle pulse, result valid
rd_data  output  1  sampled y_in
rd_sel  output  CW  channel the result belongs to
rd_err  output  1  request had an out-of-range sel
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1) forces these values immediately:
  - state IDLE, ne=0, pe=all 1s, active-channel register cleared with its valid flag = 0.
  - rd_valid=0, rd_data=0, rd_sel=0, rd_err=0, req_ready=0, busy=0.
- req_ready is registered. It rises on the first clk edge after rst deasserts. It is high exactly while state==IDLE.
- Accept occurs on an edge where req_valid && req_ready (edge E0). At E0, sel is captured and req_ready falls.
- ne and pe come from one register bank, so there is no skew between them. pe==~ne in every cycle, including reset.
- States: IDLE, BREAK, MAKE, DONE.
  - IDLE: hold the current channel closed, if any. On accept, the next state depends on sel:
    - sel >= N: go to BREAK with the error flag set.
    - sel equals the active channel: go to MAKE and skip BREAK.
    - otherwise: go to BREAK.
  - BREAK: ne=0 for exactly DEAD cycles (counter from DEAD-1 down to 0). Then go to MAKE, or to DONE if the error flag is set.
  - MAKE: ne=onehot(sel) for exactly SETTLE cycles. On the last MAKE edge, y_in is sampled into rd_data and the active channel becomes sel.
  - DONE: one cycle. rd_valid=1, rd_sel=captured sel, rd_err=error flag. Then return to IDLE; req_ready is high again the next cycle.
- Latency from E0 to the rd_valid cycle:
  - new channel: DEAD+SETTLE+1 cycles.
  - same channel: SETTLE+1 cycles.
  - error: DEAD+1 cycles, with rd_data=0, rd_err=1, all switches left open and active valid=0.
- rd_data, rd_sel and rd_err hold their values until the next DONE. rd_valid is high only in DONE.
- No two ne bits are ever high in the same cycle. No cycle goes directly from one closed channel to a different closed channel.
- req_valid with req_ready=0 is ignored; the requester must hold the request.
- Reset mid-operation, in any state: all switches open at once, no rd_valid pulse, the pending request is dropped.

Decomposition:
- tgate_pkg holds:
  - the state enum (IDLE/BREAK/MAKE/DONE);
  - the clog2-based width helper;
  - the default DEAD/SETTLE constants.
- One sub-module, tgate_en_dec: combinational sel + enable → one-hot ne, with pe=~ne. Its outputs are registered in the parent.
- Counters and the FSM stay in tgate_switch_seq.

Test Plan:
- Release reset, then request sel=2 with y_in tied to 1 → req_ready rises 1 cycle after release. ne reads 0000 for 2 cycles, then 0100 for 3 cycles. rd_valid pulses at E0+6 with rd_data=1, rd_sel=2.
- With ch2 active, request sel=1 and drive y_in=0 → ne goes 0100→0000 (2 cycles)→0010. No cycle shows two bits high. rd_data=0 at E0+6.
- With ch1 active, request sel=1 again → BREAK is skipped and ne stays 0010. rd_valid arrives at E0+4.
- N=6 build, request sel=7 → ne=000000 for 2 cycles, then rd_valid at E0+3 with rd_err=1, rd_data=0. The next valid request follows the full break path.
- Assert rst in the second MAKE cycle → ne=0 and pe=all 1s in the same cycle as rst, no rd_valid, req_ready=0 until 1 edge after release.
- Throughout all runs, check pe==~ne and popcount(ne)<=1 every cycle, and that req_valid held during busy is not accepted until IDLE.

Source files
------------

// File: rtl/tgate_pkg.sv
// Shared state encoding, width helper and timing defaults for the tgate switch sequencer.
package tgate_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StBreak = 2'd1;
    localparam state_t StMake  = 2'd2;
    localparam state_t StDone  = 2'd3;

    localparam int unsigned DefDead   = 2;
    localparam int unsigned DefSettle = 3;

    // Never returns 0 so a value range of one still gets a 1-bit vector.
    function automatic int unsigned clog2w(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tgate_en_dec.sv
// Channel index plus enable to one-hot n-side enables; p-side is the exact complement.
module tgate_en_dec
    import tgate_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = clog2w(N)
) (
    input  logic [CW-1:0] sel,
    input  logic          en,
    output logic [N-1:0]  ne,
    output logic [N-1:0]  pe
);

    // Indices >= N match no bit, so out-of-range selects leave everything open.
    always_comb begin
        ne = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (sel == CW'(i))) begin
                ne[i] = 1'b1;
            end
        end
    end

    assign pe = ~ne;

endmodule

// File: rtl/tgate_switch_seq.sv
// Break-before-make sequencer for N transmission gates on one shared node, with
// settle-then-sample readback of that node.
module tgate_switch_seq
    import tgate_pkg::*;
#(
    parameter int unsigned  N      = 4,
    parameter int unsigned  DEAD   = DefDead,
    parameter int unsigned  SETTLE = DefSettle,
    localparam int unsigned CW     = clog2w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_sel,
    output logic [N-1:0]  ne,
    output logic [N-1:0]  pe,
    input  logic          y_in,
    output logic          rd_valid,
    output logic          rd_data,
    output logic [CW-1:0] rd_sel,
    output logic          rd_err,
    output logic          busy
);

    localparam int unsigned    TW       = clog2w((DEAD > SETTLE) ? DEAD : SETTLE);
    localparam logic [TW-1:0] DeadLd   = TW'(DEAD - 1);
    localparam logic [TW-1:0] SettleLd = TW'(SETTLE - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] rd_sel_q, rd_sel_d;
    logic          err_q, err_d;
    logic          act_vld_q, act_vld_d;
    logic          ready_q, ready_d;
    logic          rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;
    logic [N-1:0]  ne_q, ne_d;
    logic [N-1:0]  pe_q, pe_d;
    logic          dec_en;
    logic [CW-1:0] dec_sel;
    logic          accept;
    logic          sel_ok;

    assign accept = req_valid & ready_q;
    assign sel_ok = 32'(req_sel) < N;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        err_d     = err_q;
        act_d     = act_q;
        act_vld_d = act_vld_q;
        rd_data_d = rd_data_q;
        rd_sel_d  = rd_sel_q;
        rd_err_d  = rd_err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    sel_d = req_sel;
                    if (!sel_ok) begin
                        err_d     = 1'b1;
                        act_vld_d = 1'b0;
                        state_d   = StBreak;
                        cnt_d     = DeadLd;
                    end else if (act_vld_q && (req_sel == act_q)) begin
                        // Already closed on this channel: no need to open it first.
                        err_d   = 1'b0;
                        state_d = StMake;
                        cnt_d   = SettleLd;
                    end else begin
                        err_d     = 1'b0;
                        act_vld_d = 1'b0;
                        state_d   = StBreak;
                        cnt_d     = DeadLd;
                    end
                end
            end
            StBreak: begin
                if (cnt_q == '0) begin
                    if (err_q) begin
                        state_d   = StDone;
                        rd_data_d = 1'b0;
                        rd_sel_d  = sel_q;
                        rd_err_d  = 1'b1;
                    end else begin
                        state_d = StMake;
                        cnt_d   = SettleLd;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StMake: begin
                if (cnt_q == '0) begin
                    state_d   = StDone;
                    rd_data_d = y_in;
                    rd_sel_d  = sel_q;
                    rd_err_d  = 1'b0;
                    act_d     = sel_q;
                    act_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready_d = (state_d == StIdle);

    // Enables are decoded from next state so ne/pe land in the same edge as the state change.
    assign dec_en  = (state_d == StMake) || ((state_d != StBreak) && act_vld_d);
    assign dec_sel = (state_d == StMake) ? sel_d : act_d;

    tgate_en_dec #(
        .N  (N),
        .CW (CW)
    ) u_en_dec (
        .sel (dec_sel),
        .en  (dec_en),
        .ne  (ne_d),
        .pe  (pe_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            act_q     <= '0;
            act_vld_q <= 1'b0;
            ready_q   <= 1'b0;
            rd_data_q <= 1'b0;
            rd_sel_q  <= '0;
            rd_err_q  <= 1'b0;
            ne_q      <= '0;
            pe_q      <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            act_q     <= act_d;
            act_vld_q <= act_vld_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
            rd_sel_q  <= rd_sel_d;
            rd_err_q  <= rd_err_d;
            ne_q      <= ne_d;
            pe_q      <= pe_d;
        end
    end

    assign req_ready = ready_q;
    assign ne        = ne_q;
    assign pe        = pe_q;
    assign rd_valid  = (state_q == StDone);
    assign rd_data   = rd_data_q;
    assign rd_sel    = rd_sel_q;
    assign rd_err    = rd_err_q;
    assign busy      = (state_q != StIdle);

endmodule
